// File: rtl/hier_path_decoder.sv
// Hierarchical path decoder: matches a digit-per-level instance path against this node's
// compiled-in path and one-hot selects the child named by the final digit.
// Optional idle timeout in RECV/DRAIN is enabled by defining HIER_PATH_DEC_TIMEOUT_EN.
module hier_path_decoder #(
  parameter int unsigned DEPTH = 20,
  parameter int unsigned FANOUT = 10,
  parameter logic [4*(DEPTH-1)-1:0] MY_PATH = 76'h3200000000000000000,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_digit,
  input  logic              in_last,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_hit,
  output logic              resp_err,
  output logic [FANOUT-1:0] resp_sel
);

  typedef enum logic [1:0] {StIdle, StRecv, StDrain, StResp} state_e;

  localparam logic [4:0]        LastIdx = 5'(DEPTH - 1);
  localparam logic [FANOUT-1:0] SelOne  = FANOUT'(1);

  state_e            state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic              err_q, err_d;
  logic              miss_q, miss_d;
  logic              in_ready_q, in_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_hit_q, resp_hit_d;
  logic              resp_err_q, resp_err_d;
  logic [FANOUT-1:0] resp_sel_q, resp_sel_d;

  logic       accept;
  logic       timeout_hit;
  logic [3:0] exp_digit;
  logic       digit_bad, is_short, is_long, is_miss;
  logic       err_n, miss_n;

  assign accept = in_valid && in_ready_q;

  // Expected digit for the current level; levels past the path read as 0 and are never compared.
  assign exp_digit = 4'(MY_PATH >> (4 * 32'(idx_q)));

  assign digit_bad = 32'(in_digit) >= FANOUT;
  assign is_short  = in_last && (idx_q < LastIdx);
  assign is_long   = !in_last && (idx_q == LastIdx);
  assign is_miss   = (idx_q < LastIdx) && (in_digit != exp_digit);
  assign err_n     = err_q | digit_bad | is_short | is_long;
  assign miss_n    = miss_q | is_miss;

`ifdef HIER_PATH_DEC_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CntW-1:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    idle_cnt_d  = '0;
    timeout_hit = 1'b0;
    if ((state_q == StRecv || state_q == StDrain) && !accept) begin
      if (32'(idle_cnt_q) + 32'd1 >= TIMEOUT) begin
        timeout_hit = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    err_d        = err_q;
    miss_d       = miss_q;
    in_ready_d   = in_ready_q;
    resp_valid_d = resp_valid_q;
    resp_hit_d   = resp_hit_q;
    resp_err_d   = resp_err_q;
    resp_sel_d   = resp_sel_q;

    unique case (state_q)
      StIdle, StRecv, StDrain: begin
        if (accept) begin
          err_d  = err_n;
          miss_d = miss_n;
          if (in_last) begin
            state_d      = StResp;
            in_ready_d   = 1'b0;
            resp_valid_d = 1'b1;
            resp_err_d   = err_n;
            resp_hit_d   = !err_n && !miss_n;
            resp_sel_d   = (!err_n && !miss_n) ? (SelOne << in_digit) : '0;
          end else begin
            // Saturate so an over-long frame in DRAIN cannot wrap back into range.
            idx_d   = (idx_q == 5'h1f) ? idx_q : idx_q + 5'd1;
            state_d = (err_n || miss_n) ? StDrain : StRecv;
          end
        end else if (timeout_hit) begin
          state_d      = StResp;
          in_ready_d   = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_hit_d   = 1'b0;
          resp_sel_d   = '0;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d      = StIdle;
          in_ready_d   = 1'b1;
          resp_valid_d = 1'b0;
          resp_hit_d   = 1'b0;
          resp_err_d   = 1'b0;
          resp_sel_d   = '0;
          idx_d        = '0;
          err_d        = 1'b0;
          miss_d       = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      err_q        <= 1'b0;
      miss_q       <= 1'b0;
      in_ready_q   <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_sel_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      err_q        <= err_d;
      miss_q       <= miss_d;
      in_ready_q   <= in_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_err_q   <= resp_err_d;
      resp_sel_q   <= resp_sel_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_err   = resp_err_q;
  assign resp_sel   = resp_sel_q;

endmodule

// File: tb/tb_hier_path_decoder.sv
// Directed self-checking bench for hier_path_decoder (default path: zeros, sb17=2, sb18=3).
module tb_hier_path_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_digit;
  logic       in_last;
  logic       resp_valid;
  logic       resp_ready;
  logic       resp_hit;
  logic       resp_err;
  logic [9:0] resp_sel;

  int passed = 0;
  int total  = 0;

  logic [3:0] frame [0:31];

  always #5 clk = ~clk;

  hier_path_decoder #(
    .DEPTH  (20),
    .FANOUT (10),
    .TIMEOUT(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_digit  (in_digit),
    .in_last   (in_last),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_hit  (resp_hit),
    .resp_err  (resp_err),
    .resp_sel  (resp_sel)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_resp(input string tag, input logic v, input logic h, input logic e,
                            input logic [9:0] s);
    check({tag, ".valid"}, {31'b0, resp_valid}, {31'b0, v});
    check({tag, ".hit"},   {31'b0, resp_hit},   {31'b0, h});
    check({tag, ".err"},   {31'b0, resp_err},   {31'b0, e});
    check({tag, ".sel"},   {22'b0, resp_sel},   {22'b0, s});
  endtask

  task automatic load_match(input logic [3:0] last_digit);
    for (int i = 0; i < 32; i++) frame[i] = 4'd0;
    frame[17] = 4'd2;
    frame[18] = 4'd3;
    frame[19] = last_digit;
  endtask

  // Drives n digits from frame[], one per cycle; returns on the negedge after the final accept.
  task automatic send(input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_digit = frame[i];
      in_last  = with_last && (i == n - 1);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic retire(input string tag);
    @(negedge clk);
    check({tag, ".retired"}, {31'b0, resp_valid}, 32'd0);
    check({tag, ".ready_back"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_digit   = 4'd0;
    in_last    = 1'b0;
    resp_ready = 1'b1;
    #3;
    check("reset.in_ready", {31'b0, in_ready}, 32'd1);
    check_resp("reset", 1'b0, 1'b0, 1'b0, 10'd0);
    @(negedge clk);
    rst = 1'b0;

    // Matching path, last digit 7
    load_match(4'd7);
    send(20, 1'b1);
    check_resp("match7", 1'b1, 1'b1, 1'b0, 10'b0010000000);
    check("match7.in_ready", {31'b0, in_ready}, 32'd0);
    retire("match7");

    // Mismatch at sb5
    load_match(4'd7);
    frame[5] = 4'd4;
    send(20, 1'b1);
    check_resp("miss_sb5", 1'b1, 1'b0, 1'b0, 10'd0);
    retire("miss_sb5");

    // Out-of-range digit at sb3
    load_match(4'd7);
    frame[3] = 4'd12;
    send(20, 1'b1);
    check_resp("digit12", 1'b1, 1'b0, 1'b1, 10'd0);
    retire("digit12");

    // Short frame: in_last on digit 15
    load_match(4'd7);
    send(15, 1'b1);
    check_resp("short15", 1'b1, 1'b0, 1'b1, 10'd0);
    retire("short15");

    // Long frame: 20 digits without last, nothing yet; 21st carries last
    load_match(4'd7);
    send(20, 1'b0);
    check("long.no_resp_at_20", {31'b0, resp_valid}, 32'd0);
    frame[0] = 4'd0;
    send(1, 1'b1);
    check_resp("long21", 1'b1, 1'b0, 1'b1, 10'd0);
    retire("long21");

    // Mismatch and short together: error wins
    load_match(4'd7);
    frame[5] = 4'd4;
    send(10, 1'b1);
    check_resp("miss_short", 1'b1, 1'b0, 1'b1, 10'd0);
    retire("miss_short");

    // Final digit out of range
    load_match(4'd10);
    send(20, 1'b1);
    check_resp("last10", 1'b1, 1'b0, 1'b1, 10'd0);
    retire("last10");

    // Backpressure: response held for 5 cycles while a digit is offered
    resp_ready = 1'b0;
    load_match(4'd9);
    send(20, 1'b1);
    in_valid = 1'b1;
    in_digit = 4'd5;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check_resp("hold", 1'b1, 1'b1, 1'b0, 10'b1000000000);
      check("hold.in_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
    end
    in_valid   = 1'b0;
    in_last    = 1'b0;
    resp_ready = 1'b1;
    retire("hold");

    // Frame following the hold must be clean
    load_match(4'd1);
    send(20, 1'b1);
    check_resp("after_hold", 1'b1, 1'b1, 1'b0, 10'b0000000010);
    retire("after_hold");

    // Reset mid-frame after 8 digits
    load_match(4'd7);
    send(8, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst_mid.in_ready", {31'b0, in_ready}, 32'd1);
    check_resp("rst_mid", 1'b0, 1'b0, 1'b0, 10'd0);
    @(negedge clk);
    rst = 1'b0;
    load_match(4'd0);
    send(20, 1'b1);
    check_resp("after_rst", 1'b1, 1'b1, 1'b0, 10'b0000000001);

    // Reset while a response is pending clears it at once
    resp_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_resp.in_ready", {31'b0, in_ready}, 32'd1);
    check_resp("rst_resp", 1'b0, 1'b0, 1'b0, 10'd0);
    @(negedge clk);
    rst        = 1'b0;
    resp_ready = 1'b1;

    // Three digits then four idle cycles
    load_match(4'd7);
    send(3, 1'b0);
    repeat (4) @(negedge clk);
`ifdef HIER_PATH_DEC_TIMEOUT_EN
    check_resp("timeout", 1'b1, 1'b0, 1'b1, 10'd0);
    retire("timeout");
`else
    check_resp("no_timeout", 1'b0, 1'b0, 1'b0, 10'd0);
    repeat (20) @(negedge clk);
    check("no_timeout.late", {31'b0, resp_valid}, 32'd0);
    check("no_timeout.in_ready", {31'b0, in_ready}, 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hier_path_decoder.md
# hier_path_decoder

Receives a hierarchical instance path as a stream of decimal digits, one digit per level from the root downward. If the first DEPTH-1 digits match this node's compiled-in path, the final digit is decoded into a one-hot select across FANOUT child instances. The block sits at a generated tree node and is the receive end of the path addressing used to build the tree. It reports each frame as a hit, a miss or an error through a registered valid/ready response.

## Interface
- DEPTH, 20: digits per frame (levels sb0..sb19); must be at least 2.
- FANOUT, 10: number of children; legal digit values are 0..FANOUT-1.
- MY_PATH, 76'h3200000000000000000: this node's path; digit i in bits [4i+3:4i] for i = 0..DEPTH-2. Default is 0 at every level except sb17=2 and sb18=3.
- TIMEOUT, 255: idle-cycle limit; used only when HIER_PATH_DEC_TIMEOUT_EN is defined.

Ports:
- clk  in  1  the single clock; everything is on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  a digit is offered.
- in_ready  out  1  the block can accept a digit.
- in_digit  in  4  the path digit.
- in_last  in  1  this is the last digit of the frame.
- resp_valid  out  1  a response is pending.
- resp_ready  in  1  the consumer accepts the response.
- resp_hit  out  1  the path matched this node.
- resp_err  out  1  the frame was malformed (or timed out).
- resp_sel  out  FANOUT  one-hot child select; nonzero only when resp_hit=1.

## Operation
- States:
  - IDLE, RECV and DRAIN: in_ready=1 in all three.
  - RESP: in_ready=0.
- A digit is accepted when in_valid && in_ready. The 5-bit index idx counts accepted digits and is reset to 0 at the start of every frame.
- The first digit is accepted in IDLE; the state then moves to RECV, or to a response or DRAIN per the rules below.
- Checks on each accepted digit, in priority order:
  1. in_digit >= FANOUT: set the err flag.
  2. in_last with idx < DEPTH-1 (frame too short): set err.
  3. idx == DEPTH-1 without in_last (frame too long): set err.
  4. idx < DEPTH-1 and in_digit != MY_PATH[idx]: set the miss flag.
- Any flag set before the last digit sends the state to DRAIN. DRAIN accepts and discards digits until in_last.
- When in_last is accepted (from IDLE, RECV or DRAIN), the state moves to RESP:
  - err set: resp_err=1, resp_hit=0, resp_sel=0.
  - miss set, no err: resp_hit=0, resp_err=0, resp_sel=0.
  - otherwise: resp_hit=1, resp_sel = 1 << last digit.
- Error outranks miss: a frame that both mismatches and is malformed reports resp_err=1 only.
- In RESP, the response fields are held stable while resp_valid=1. When resp_valid && resp_ready, the state returns to IDLE and the flags and idx clear.
- Reset values: state=IDLE, in_ready=1, resp_valid=0, resp_hit=0, resp_err=0, resp_sel=0, idx=0, flags clear.
- Reset during a frame discards the frame. No response is ever produced for a frame cut by reset.

## Timing
- resp_valid rises on the clock edge that accepts the in_last digit; it is visible the cycle after acceptance (1-cycle latency).
- Throughput:
  - in_ready drops while in RESP, so there is no overlap between frames.
  - With resp_ready held at 1, a new frame can start 2 cycles after the previous in_last: one cycle in RESP, then IDLE.
- in_valid=0 in any state leaves all state unchanged (with the timeout feature disabled).
- resp_ready is ignored outside RESP.
- All outputs are registered; none is combinational from the inputs.

## Configuration
- HIER_PATH_DEC_TIMEOUT_EN defined:
  - An idle counter runs in RECV and DRAIN. It clears on every accepted digit.
  - When it reaches TIMEOUT, the state moves to RESP with resp_err=1, resp_hit=0, resp_sel=0, without waiting for in_last.
  - Digits arriving afterwards start a new frame once the response is accepted.
- Not defined: no counter exists, and a frame may stall indefinitely in RECV or DRAIN.

## Test plan
- Matching path 0 (×17), 2, 3, 7, with in_last on digit 20 and resp_ready=1 -> one cycle later resp_valid=1, resp_hit=1, resp_sel=10'b0010000000, resp_err=0.
- Same path with digit sb5=4 -> DRAIN, then resp_hit=0, resp_err=0, resp_sel=0.
- Digit 12 at sb3 -> resp_err=1. Separately, in_last on digit 15 -> resp_err=1. Separately, 21 digits -> resp_err=1 after the 21st.
- Matching frame with resp_ready=0 for 5 cycles -> response held stable, in_ready=0 throughout, and the response retires on the cycle resp_ready=1.
- rst pulsed mid-cycle after 8 digits -> all outputs take their reset values immediately. A following full matching frame ending in digit 0 -> resp_sel=10'b0000000001.
- With HIER_PATH_DEC_TIMEOUT_EN and TIMEOUT=4: 3 digits, then 4 idle cycles -> resp_valid=1, resp_err=1. Without the macro, the same stimulus -> no response.
